// File: rtl/apu_pkg.sv
// Shared APU definitions: frame-sequencer schedule masks, default prescaler width
// and a helper that maps a step index to its tick pulses.
package apu_pkg;

    localparam int          FS_STEPS      = 8;
    localparam int          FS_DIV_WIDTH  = 13;
    localparam logic [7:0]  FS_LEN_MASK   = 8'b0101_0101;
    localparam logic [7:0]  FS_SWEEP_MASK = 8'b0100_0100;
    localparam logic [7:0]  FS_ENV_MASK   = 8'b1000_0000;

    typedef logic [$clog2(FS_STEPS)-1:0] fs_step_t;

    typedef struct packed {
        logic len;
        logic sweep;
        logic env;
    } fs_ticks_t;

    // Bit n of each mask says whether step n clocks that unit.
    function automatic fs_ticks_t fs_step_ticks(input fs_step_t s);
        fs_ticks_t t;
        t.len   = FS_LEN_MASK[s];
        t.sweep = FS_SWEEP_MASK[s];
        t.env   = FS_ENV_MASK[s];
        return t;
    endfunction

endpackage

// File: rtl/fs_prescaler.sv
// DIV-style free-running prescaler producing the frame-edge strobe.
// Optional FS_DIV_GLITCH_EN: a DIV write while the MSB is set also counts as an edge.
module fs_prescaler
    import apu_pkg::*;
#(
    parameter int DIV_WIDTH = FS_DIV_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_div_reset,
    output logic o_frame_edge
);

    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_nat_edge;
    logic                 w_glitch_edge;

    // Natural edge is the wrap from all-ones; the MSB falls on this clock.
    assign w_nat_edge = &r_div;

`ifdef FS_DIV_GLITCH_EN
    // Clearing DIV with the MSB high drops the MSB just like a wrap would.
    assign w_glitch_edge = i_div_reset & r_div[DIV_WIDTH-1];
`else
    assign w_glitch_edge = 1'b0;
`endif

    // A DIV write at all-ones hits both terms, but OR-ing them yields one edge.
    assign o_frame_edge = w_nat_edge | w_glitch_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (i_div_reset) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// 512 Hz frame sequencer: walks the 8-step schedule and emits single-cycle
// length / sweep / envelope clock enables. Optional macro: FS_DIV_GLITCH_EN.
module frame_sequencer
    import apu_pkg::*;
#(
    parameter int DIV_WIDTH = FS_DIV_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       apu_en,
    input  logic       div_reset,
    output logic       len_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic [2:0] step,
    output logic       len_next_clocks
);

    logic      w_frame_edge;
    fs_ticks_t w_step_ticks;
    fs_step_t  r_step;
    fs_ticks_t r_ticks;

    fs_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_div_reset  (div_reset),
        .o_frame_edge (w_frame_edge)
    );

    assign w_step_ticks = fs_step_ticks(r_step);

    // Powered down parks at step 0 so power-up always begins with a length clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= '0;
            r_ticks <= '0;
        end else if (!apu_en) begin
            r_step  <= '0;
            r_ticks <= '0;
        end else if (w_frame_edge) begin
            r_step  <= r_step + 1'b1;
            r_ticks <= w_step_ticks;
        end else begin
            r_ticks <= '0;
        end
    end

    assign len_tick        = r_ticks.len;
    assign sweep_tick      = r_ticks.sweep;
    assign env_tick        = r_ticks.env;
    assign step            = r_step;
    assign len_next_clocks = apu_en ? ~r_step[0] : 1'b1;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer (DIV_WIDTH=3) with a per-cycle expectation scoreboard.
module tb_frame_sequencer;

    localparam int DW   = 3;
    localparam int DMAX = (1 << DW) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       apu_en = 1'b0;
    logic       div_reset = 1'b0;
    logic       len_tick, sweep_tick, env_tick, len_next_clocks;
    logic [2:0] step;

    frame_sequencer #(.DIV_WIDTH(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .apu_en          (apu_en),
        .div_reset       (div_reset),
        .len_tick        (len_tick),
        .sweep_tick      (sweep_tick),
        .env_tick        (env_tick),
        .step            (step),
        .len_next_clocks (len_next_clocks)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       len;
        logic       sweep;
        logic       env;
        logic [2:0] stp;
        logic       lnc;
    } exp_t;

    exp_t sb[$];
    int   m_div  = 0;
    int   m_step = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle: predict outputs after the coming edge, then compare.
    task automatic cycle(input logic en, input logic dr);
        exp_t e;
        logic edge_now;
        apu_en    = en;
        div_reset = dr;
        edge_now  = (m_div == DMAX);
`ifdef FS_DIV_GLITCH_EN
        if (dr && m_div >= (1 << (DW - 1))) edge_now = 1'b1;
`endif
        e = '{len: 1'b0, sweep: 1'b0, env: 1'b0, stp: 3'd0, lnc: 1'b1};
        if (!en) begin
            m_step = 0;
        end else if (edge_now) begin
            case (m_step)
                0, 4:    e.len = 1'b1;
                2, 6:    begin e.len = 1'b1; e.sweep = 1'b1; end
                7:       e.env = 1'b1;
                default: ;
            endcase
            m_step = (m_step + 1) % 8;
        end
        m_div = dr ? 0 : (m_div + 1) % (DMAX + 1);
        e.stp = m_step[2:0];
        e.lnc = en ? ~m_step[0] : 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("len_tick",        int'(len_tick),        int'(e.len));
        chk("sweep_tick",      int'(sweep_tick),      int'(e.sweep));
        chk("env_tick",        int'(env_tick),        int'(e.env));
        chk("step",            int'(step),            int'(e.stp));
        chk("len_next_clocks", int'(len_next_clocks), int'(e.lnc));
    endtask

    task automatic seek(input int tgt_div, input int tgt_step, input string tag);
        int n = 0;
        while (!(m_div == tgt_div && (tgt_step < 0 || m_step == tgt_step)) && n < 300) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        chk({tag, "_seek_timeout"}, int'(n < 300), 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_len"},   int'(len_tick),        0);
        chk({tag, "_sweep"}, int'(sweep_tick),      0);
        chk({tag, "_env"},   int'(env_tick),        0);
        chk({tag, "_step"},  int'(step),            0);
        chk({tag, "_lnc"},   int'(len_next_clocks), 1);
    endtask

    initial begin
        int first_len;
        int env_a;
        int env_b;
        int n;

        // Reset and release with apu_en high
        apu_en = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n  = 1'b1;
        m_div  = 0;
        m_step = 0;

        first_len = -1; env_a = -1; env_b = -1;
        for (int i = 1; i <= 140; i++) begin
            cycle(1'b1, 1'b0);
            if (len_tick && first_len < 0) first_len = i;
            if (env_tick) begin
                if (env_a < 0) env_a = i;
                else if (env_b < 0) env_b = i;
            end
        end
        chk("first_len_latency", first_len, 8);
        chk("first_env_cycle", env_a, 64);
        chk("env_period", env_b - env_a, 64);

        // Powered down: held at step 0, no ticks
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0);
        n = 0;
        while (!len_tick && n < 20) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        chk("powerup_len_seen", int'(len_tick), 1);
        chk("powerup_step", int'(step), 1);

        // apu_en falls on the frame edge of step 6
        seek(DMAX, 6, "drop_en");
        cycle(1'b0, 1'b0);
        chk("drop_en_no_len", int'(len_tick), 0);
        chk("drop_en_step0", int'(step), 0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

        // div_reset with MSB clear
        seek(2, -1, "divrst_lo");
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

        // div_reset with MSB set (glitch edge when enabled)
        seek(5, -1, "divrst_hi");
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

        // div_reset coinciding with the natural edge
        seek(DMAX, -1, "divrst_edge");
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

        // Asynchronous reset mid-count at step 5
        seek(3, 5, "async_rst");
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_rst_now");
        m_div  = 0;
        m_step = 0;
        @(posedge clk);
        #1;
        check_reset_values("async_rst_hold");
        rst_n = 1'b1;
        n = 0;
        while (!len_tick && n < 20) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        chk("restart_latency", n, 8);
        chk("restart_step", int'(step), 1);
        for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Scheduler that times every channel-modulation unit in the sound chip. It divides the 4.194304 MHz system clock down to the 512 Hz frame-sequencer rate. It steps through the 8-step Game Boy schedule and issues single-cycle enable pulses: length (256 Hz), sweep (128 Hz) and envelope (64 Hz). The length counters, the channel-1 sweep unit and the envelope units consume these pulses as clock enables in the `clk` domain, replacing ad-hoc low-rate clocks.

## Interface
- `DIV_WIDTH`, 13: prescaler width. Frame edge every 2^DIV_WIDTH clocks (8192 gives 512 Hz at 4.194304 MHz).
- `clk` in 1: system clock, 4.194304 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `apu_en` in 1: NR52 bit 7 master power. Low holds the sequencer idle at step 0.
- `div_reset` in 1: single-cycle pulse, CPU write to DIV. Clears the prescaler.
- `len_tick` out 1: one-cycle pulse at 256 Hz (steps 0, 2, 4, 6).
- `sweep_tick` out 1: one-cycle pulse at 128 Hz (steps 2, 6).
- `env_tick` out 1: one-cycle pulse at 64 Hz (step 7).
- `step` out 3: index of the next step to be executed.
- `len_next_clocks` out 1: high when the next step clocks length (`step` even). Length counters use it for the enable-write extra-clock rule.

## Operation
- Prescaler `div` (DIV_WIDTH bits) increments every cycle and wraps to 0. It runs regardless of `apu_en`, because it models the system DIV counter.
- Frame edge: the cycle in which `div == 2^DIV_WIDTH-1` and `div` increments (falling edge of the MSB).
- On a frame edge with `apu_en` high:
  - Pulses for the current `step` are registered.
  - `step` increments modulo 8 (7 wraps to 0).
- Step schedule:
  - 0: len
  - 1: none
  - 2: len + sweep
  - 3: none
  - 4: len
  - 5: none
  - 6: len + sweep
  - 7: env
- `apu_en` low:
  - `step` is forced to 0 and all tick outputs are 0.
  - On the rising edge of `apu_en`, the first frame edge executes step 0.
- `div_reset`: `div` becomes 0 on the next clock edge and continues counting from 0. This overrides increment and wrap.
- `len_next_clocks` = `~step[0]` while `apu_en` is high, and 1 while it is low (step 0 is next).
- Simultaneous events:
  - `div_reset` together with a natural frame edge: one step only, never two.
  - `apu_en` falling on a frame-edge cycle: no pulse; `step` goes to 0.
- Reset values: `div`=0, `step`=0, `len_tick`=`sweep_tick`=`env_tick`=0, `len_next_clocks`=1.

## Timing
- Tick outputs are registered. A pulse is high for exactly the one cycle following the frame-edge clock edge.
- `step` updates on that same edge, so during a pulse cycle `step` already shows the following index.
- Period with no `div_reset`:
  - `len_tick`: 16384 clocks.
  - `sweep_tick`: 32768 clocks.
  - `env_tick`: 65536 clocks, with DIV_WIDTH=13.
- At most one of {`len_tick`, `env_tick`} is high in any cycle. `sweep_tick` only coincides with `len_tick`.
- Asynchronous `rst_n` assertion mid-count clears everything immediately. The first frame edge occurs 2^DIV_WIDTH clocks after deassertion.

## Configuration
- `FS_DIV_GLITCH_EN` defined:
  - A `div_reset` while `div[DIV_WIDTH-1]` is 1 is treated as a falling edge, matching DMG hardware.
  - If `apu_en` is high, it executes the current step immediately: pulses in the next cycle and `step` advances.
  - The `div_reset` + natural-edge case still produces a single step.
- Not defined: `div_reset` only clears `div`, with no extra step.

## Structure
- Shared package `apu_pkg` holds:
  - `FS_STEPS` = 8.
  - 8-bit step masks `FS_LEN_MASK` = 8'b0101_0101, `FS_SWEEP_MASK` = 8'b0100_0100, `FS_ENV_MASK` = 8'b1000_0000.
  - Default `FS_DIV_WIDTH` = 13.
- Sub-module `fs_prescaler` (DIV_WIDTH counter, `div_reset`, frame-edge and glitch-edge detection). The top level holds the step counter and pulse registers.

## Test plan
- Reset, `apu_en`=1, DIV_WIDTH=3 -> first `len_tick` 8 cycles after reset release. Then `len_tick` every 16 cycles, `sweep_tick` with the 2nd and 4th `len_tick`, `env_tick` every 64 cycles, 8 cycles after step 6.
- Hold `apu_en`=0 for 100 cycles -> no ticks, `step`=0, `len_next_clocks`=1. Raise `apu_en` -> next frame edge pulses `len_tick` with `step` going to 1.
- Drop `apu_en` on a frame-edge cycle at step 6 -> no `len_tick`/`sweep_tick`; `step`=0 next cycle.
- `div_reset` at `div`=2 (MSB 0), DIV_WIDTH=3 -> next frame edge 8 cycles later, with no extra step in either build.
- `div_reset` at `div`=5 (MSB 1) -> with `FS_DIV_GLITCH_EN`, immediate pulse for the current step and `step`+1, then the next edge 8 cycles later. Without it, no pulse.
- Assert `rst_n` low mid-count at step 5 -> all outputs at reset values in the same cycle, and the schedule restarts at step 0.
